// File: rtl/riscv_core_mul_in.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_mul_in
// Purpose  : RV64M multiply front end. Derives the operand sign flags and forms
//            the unsigned 2*XLEN magnitude product with a radix-2 shift-add loop.
//            Optional: MUL_IN_EARLY_TERM_EN ends BUSY once the multiplier is zero.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_mul_in #(
  parameter int XLEN = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mul_in_valid,
  output logic              o_mul_in_ready,
  input  logic [XLEN-1:0]   i_mul_in_srcA,
  input  logic [XLEN-1:0]   i_mul_in_srcB,
  input  logic [1:0]        i_mul_in_control,
  input  logic              i_mul_in_isword,
  input  logic              i_mul_in_flush,
  output logic              o_mul_in_valid,
  input  logic              i_mul_in_ready,
  output logic              o_mul_in_srcA_Dsign,
  output logic              o_mul_in_srcB_Dsign,
  output logic              o_mul_in_srcA_Wsign,
  output logic              o_mul_in_srcB_Wsign,
  output logic [1:0]        o_mul_in_control,
  output logic              o_mul_in_isword,
  output logic [2*XLEN-1:0] o_mul_in_product
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic            a_dsign_q, b_dsign_q, a_wsign_q, b_wsign_q;
  logic [1:0]      control_q;
  logic            isword_q;
  logic [PW-1:0]   mcand_q, acc_q;
  logic [XLEN-1:0] mplr_q;
  logic [CW-1:0]   count_q;

  logic            a_dsign_d, b_dsign_d, a_wsign_d, b_wsign_d;
  logic [31:0]     a_word, b_word, a_word_mag, b_word_mag;
  logic [XLEN-1:0] a_mag_d, b_mag_d;
  logic [PW-1:0]   mcand_d, acc_d;
  logic [XLEN-1:0] mplr_d;
  logic [CW-1:0]   count_d;
  logic            last_d;

  always_comb begin
    a_dsign_d = !i_mul_in_isword && (i_mul_in_control != 2'b11) && i_mul_in_srcA[XLEN-1];
    b_dsign_d = !i_mul_in_isword && !i_mul_in_control[1] && i_mul_in_srcB[XLEN-1];
    a_wsign_d = i_mul_in_isword && (i_mul_in_control == 2'b00) && i_mul_in_srcA[31];
    b_wsign_d = i_mul_in_isword && (i_mul_in_control == 2'b00) && i_mul_in_srcB[31];

    a_word     = i_mul_in_srcA[31:0];
    b_word     = i_mul_in_srcB[31:0];
    a_word_mag = a_wsign_d ? (~a_word + 32'd1) : a_word;
    b_word_mag = b_wsign_d ? (~b_word + 32'd1) : b_word;

    // Negating the most negative value wraps to itself, which read unsigned is exactly 2^(W-1).
    if (i_mul_in_isword) begin
      a_mag_d = {{(XLEN-32){1'b0}}, a_word_mag};
      b_mag_d = {{(XLEN-32){1'b0}}, b_word_mag};
    end else begin
      a_mag_d = a_dsign_d ? (~i_mul_in_srcA + XLEN'(1)) : i_mul_in_srcA;
      b_mag_d = b_dsign_d ? (~i_mul_in_srcB + XLEN'(1)) : i_mul_in_srcB;
    end
  end

  always_comb begin
    acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d = mcand_q << 1;
    mplr_d  = mplr_q >> 1;
    count_d = count_q - CW'(1);
`ifdef MUL_IN_EARLY_TERM_EN
    last_d  = (count_d == '0) || (mplr_d == '0);
`else
    last_d  = (count_d == '0);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      a_dsign_q <= 1'b0;
      b_dsign_q <= 1'b0;
      a_wsign_q <= 1'b0;
      b_wsign_q <= 1'b0;
      control_q <= 2'b00;
      isword_q  <= 1'b0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_mul_in_valid && !i_mul_in_flush) begin
            a_dsign_q <= a_dsign_d;
            b_dsign_q <= b_dsign_d;
            a_wsign_q <= a_wsign_d;
            b_wsign_q <= b_wsign_d;
            control_q <= i_mul_in_control;
            isword_q  <= i_mul_in_isword;
            mcand_q   <= {{XLEN{1'b0}}, a_mag_d};
            mplr_q    <= b_mag_d;
            acc_q     <= '0;
            count_q   <= i_mul_in_isword ? CW'(32) : CW'(XLEN);
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (i_mul_in_flush) begin
            state_q <= IDLE;
          end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            count_q <= count_d;
            if (last_d) state_q <= DONE;
          end
        end
        DONE: begin
          if (i_mul_in_flush || i_mul_in_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mul_in_ready      = (state_q == IDLE);
  assign o_mul_in_valid      = (state_q == DONE);
  assign o_mul_in_srcA_Dsign = a_dsign_q;
  assign o_mul_in_srcB_Dsign = b_dsign_q;
  assign o_mul_in_srcA_Wsign = a_wsign_q;
  assign o_mul_in_srcB_Wsign = b_wsign_q;
  assign o_mul_in_control    = control_q;
  assign o_mul_in_isword     = isword_q;
  assign o_mul_in_product    = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_mul_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_mul_in
// Purpose  : Directed vector table plus hand-written flush/reset/hold sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_mul_in;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready_o, out_valid, out_ready;
  logic [63:0]  srcA, srcB;
  logic [1:0]   ctrl, ctrl_o;
  logic         isw, isw_o, flush;
  logic         ad, bd, aw, bw;
  logic [127:0] prod;

  int pass_cnt  = 0;
  int total_cnt = 0;

  riscv_core_mul_in #(.XLEN(64)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_mul_in_valid      (in_valid),
    .o_mul_in_ready      (in_ready_o),
    .i_mul_in_srcA       (srcA),
    .i_mul_in_srcB       (srcB),
    .i_mul_in_control    (ctrl),
    .i_mul_in_isword     (isw),
    .i_mul_in_flush      (flush),
    .o_mul_in_valid      (out_valid),
    .i_mul_in_ready      (out_ready),
    .o_mul_in_srcA_Dsign (ad),
    .o_mul_in_srcB_Dsign (bd),
    .o_mul_in_srcA_Wsign (aw),
    .o_mul_in_srcB_Wsign (bw),
    .o_mul_in_control    (ctrl_o),
    .o_mul_in_isword     (isw_o),
    .o_mul_in_product    (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   ctrl;
    logic         isw;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         ad, bd, aw, bw;
    logic [127:0] prod;
    int           lat;
    int           lat_et;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] c, input logic w, input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    while (!in_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("ready_timeout", 128'(in_ready_o), 128'd1);
    ctrl = c; isw = w; srcA = a; srcB = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("valid_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, exp_lat;
`ifdef MUL_IN_EARLY_TERM_EN
    exp_lat = v.lat_et;
`else
    exp_lat = v.lat;
`endif
    start_op(v.ctrl, v.isw, v.a, v.b);
    chk($sformatf("ready_low[%0d]", idx), 128'(in_ready_o), 128'd0);
    wait_valid(lat);
    chk($sformatf("latency[%0d]", idx), 128'(lat), 128'(exp_lat));
    chk($sformatf("product[%0d]", idx), prod, v.prod);
    chk($sformatf("signs[%0d]", idx), 128'({ad, bd, aw, bw}), 128'({v.ad, v.bd, v.aw, v.bw}));
    chk($sformatf("ctrl_isw[%0d]", idx), 128'({ctrl_o, isw_o}), 128'({v.ctrl, v.isw}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("consumed[%0d]", idx), 128'({in_ready_o, out_valid}), 128'b10);
  endtask

  initial begin
    int lat, vcount;

    //            ctrl   isw   a                        b                        ad bd aw bw prod                                         lat et
    vecs[0]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                   1, 0, 0, 0, 128'd15,                                     64, 3};
    vecs[1]  = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64, 64};
    vecs[2]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'd2,                   0, 0, 1, 0, 128'h1_0000_0000,                            32, 2};
    vecs[3]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0, 0, 0, 128'h8000_0000_0000_0000,                  64, 64};
    vecs[4]  = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 128'd1,                                      64, 1};
    vecs[5]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,                   0, 0, 0, 0, 128'h2_FFFF_FFFD,                            32, 2};
    vecs[6]  = '{2'b00, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0, 0, 1, 1, 128'd1,                                      32, 1};
    vecs[7]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 128'h4000_0000_0000_0000_0000_0000_0000_0000, 64, 64};
    vecs[8]  = '{2'b00, 1'b0, 64'd5,                   64'd0,                   0, 0, 0, 0, 128'd0,                                      64, 1};
    vecs[9]  = '{2'b00, 1'b1, 64'h1234_5678_0000_0003, 64'hABCD_EF00_0000_0004, 0, 0, 0, 0, 128'd12,                                     32, 3};
    vecs[10] = '{2'b00, 1'b0, 64'd7,                   64'd1,                   0, 0, 0, 0, 128'd7,                                      64, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    srcA = '0; srcB = '0; ctrl = 2'b00; isw = 1'b0;
    repeat (2) tick();
    chk("reset_hs", 128'({in_ready_o, out_valid}), 128'b10);
    chk("reset_flags", 128'({ad, bd, aw, bw, ctrl_o, isw_o}), 128'd0);
    chk("reset_prod", prod, 128'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Hold the result in DONE with downstream stalled and a competing request.
    start_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    wait_valid(lat);
    chk("hold_latency", 128'(lat), 128'd64);
    in_valid = 1'b1; srcA = 64'd9; srcB = 64'd9; ctrl = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_hs[%0d]", k), 128'({out_valid, in_ready_o}), 128'b10);
      chk($sformatf("hold_prod[%0d]", k), prod, 128'h8000_0000_0000_0000);
      chk($sformatf("hold_ctrl[%0d]", k), 128'({ctrl_o, ad, bd}), 128'b1010);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release", 128'({in_ready_o, out_valid}), 128'b10);

    // Flush while IDLE must block acceptance.
    in_valid = 1'b1; flush = 1'b1; srcA = 64'd1; srcB = 64'd1; ctrl = 2'b00;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_block", 128'({in_ready_o, out_valid}), 128'b10);

    // Flush ten cycles into BUSY; the multiplier's top bit keeps it busy in every build.
    start_op(2'b11, 1'b0, 64'd3, 64'h8000_0000_0000_0003);
    repeat (9) tick();
    chk("busy_before_flush", 128'({in_ready_o, out_valid}), 128'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("busy_flush_idle", 128'({in_ready_o, out_valid}), 128'b10);
    vcount = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (out_valid) vcount++;
    end
    chk("flush_no_valid", 128'(vcount), 128'd0);
    run_vec('{2'b00, 1'b0, 64'd7, 64'd6, 0, 0, 0, 0, 128'd42, 64, 3}, 11);

    // Flush together with downstream ready in DONE.
    start_op(2'b00, 1'b0, 64'd7, 64'd1);
    wait_valid(lat);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("done_flush_ready", 128'({in_ready_o, out_valid}), 128'b10);

    // Asynchronous reset in the middle of BUSY.
    start_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0006);
    repeat (5) tick();
    chk("pre_reset_state", 128'({ctrl_o, ad, in_ready_o}), 128'b1010);
    rst = 1'b1;
    #1;
    chk("midrst_hs", 128'({in_ready_o, out_valid}), 128'b10);
    chk("midrst_flags", 128'({ad, bd, aw, bw, ctrl_o, isw_o}), 128'd0);
    chk("midrst_prod", prod, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    run_vec(vecs[10], 12);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_core_mul_in.md
# riscv_core_mul_in

Iterative front end of the RV64M multiply path. It accepts two XLEN operands and the M-extension control, and derives the per-operand double-word and word sign flags. It multiplies the operand magnitudes with a radix-2 shift-add datapath and presents the unsigned 2·XLEN product, the sign flags and the control to riscv_core_mul_out. riscv_core_mul_out then applies the sign correction and selects the result.

## Interface
- XLEN, 64, operand width; the product is 2·XLEN.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_mul_in_valid  in  1  request valid.
- o_mul_in_ready  out  1  block can accept a request.
- i_mul_in_srcA  in  XLEN  operand A (rs1).
- i_mul_in_srcB  in  XLEN  operand B (rs2).
- i_mul_in_control  in  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU.
- i_mul_in_isword  in  1  word op (MULW).
- i_mul_in_flush  in  1  synchronous kill of the in-flight op.
- o_mul_in_valid  out  1  result valid.
- i_mul_in_ready  in  1  downstream accepts the result.
- o_mul_in_srcA_Dsign, o_mul_in_srcB_Dsign  out  1 each  double-word sign flags.
- o_mul_in_srcA_Wsign, o_mul_in_srcB_Wsign  out  1 each  word sign flags.
- o_mul_in_control  out  2  captured control.
- o_mul_in_isword  out  1  captured isword.
- o_mul_in_product  out  2·XLEN  unsigned magnitude product.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- o_mul_in_ready = (state == IDLE). o_mul_in_valid = (state == DONE).
- Acceptance happens when IDLE, valid is high and flush is low. On acceptance:
  - sign flags, control and isword are registered;
  - multiplicand, multiplier and accumulator registers are loaded;
  - the iteration count N is loaded: 64 (XLEN) for double-word ops, 32 for word ops;
  - state goes to BUSY.
- Double-word signs (isword = 0):
  - Asign = srcA[XLEN-1] for control 00, 01 and 10; 0 for 11.
  - Bsign = srcB[XLEN-1] for control 00 and 01; 0 for 10 and 11.
  - Both Wsign flags are 0.
- Word signs (isword = 1):
  - Asign = srcA[31] and Bsign = srcB[31] when control = 00; otherwise both 0.
  - Both Dsign flags are 0.
- Magnitude: the two's complement of the operand when its sign flag is set, otherwise the operand.
  - Word ops use only the low 32 bits, zero-extended.
  - The most negative value maps to the unsigned 2^(XLEN-1), or 2^31 for word ops; no overflow.
- BUSY, once per cycle:
  - if mplr[0] = 1, acc = acc + mcand (2·XLEN width, no carry-out possible);
  - then mcand <<= 1, mplr >>= 1, count decrements;
  - when count reaches 0 after the update, the next state is DONE.
- DONE: all outputs are held stable. On i_mul_in_ready = 1 the next state is IDLE.
- o_mul_in_product = acc, driven continuously and meaningful only while valid.
- Flush has priority over every other event:
  - from BUSY or DONE, the next state is IDLE;
  - valid drops the following cycle; no result is delivered;
  - while IDLE, flush blocks acceptance in the same cycle.
- Reset forces IDLE and clears every register, mid-operation included.

## Timing
- Reset values:
  - o_mul_in_ready = 1;
  - o_mul_in_valid = 0;
  - all sign flags, o_mul_in_control and o_mul_in_isword = 0;
  - o_mul_in_product = 0.
- Latency: acceptance at edge E0 gives o_mul_in_valid high after edge E0+N (64 or 32 cycles, without the configuration macro).
- Throughput: one op per N+2 cycles at best, because the DONE to IDLE to accept sequence costs one cycle.
- Ready is low from the cycle after acceptance until DONE is consumed; no combinational path from i_mul_in_valid to o_mul_in_ready.
- Simultaneous flush and i_mul_in_ready in DONE: the next state is IDLE; the result counts as consumed.

## Configuration
- MUL_IN_EARLY_TERM_EN defined:
  - BUSY also goes to DONE when the post-shift multiplier register is zero;
  - the minimum is 1 BUSY cycle (multiplier magnitude 0 or 1) and latency = max(1, index of the highest set bit of the multiplier magnitude + 1);
  - the product value is unchanged.
- Macro undefined: fixed N-cycle latency, independent of the data.

## Test plan
- MUL, srcA = -3, srcB = 5 → Asign = 1, Bsign = 0, product = 15, valid 64 cycles after acceptance.
- MULHU, both operands 0xFFFF_FFFF_FFFF_FFFF → both sign flags 0, product = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- MULW, srcA = 0x0000_0000_8000_0000, srcB = 2 → Awsign = 1, Bwsign = 0, both Dsign flags 0, product = 0x1_0000_0000, 32-cycle latency.
- MULHSU, srcA = -1, srcB = 0x8000_0000_0000_0000 → Asign = 1, Bsign = 0, product = 0x8000_0000_0000_0000. Hold i_mul_in_ready low 5 cycles in DONE: product is stable, ready stays 0, a new valid is ignored.
- Flush 10 cycles into BUSY → IDLE next cycle, valid is never asserted, the next MUL 7×6 gives product 42. Assert i_rst mid-BUSY → all outputs return to their reset values immediately.
- With MUL_IN_EARLY_TERM_EN defined, MUL 7×1 → valid 1 cycle after acceptance, product 7. Without the macro → valid after 64 cycles, product 7.
